// File: rtl/result_write_arbiter_pkg.sv
// Shared types and constants for the result write arbiter and its lane FIFOs.
package result_write_arbiter_pkg;

   localparam int DEF_NUM_PARALLEL_BITS = 1;
   localparam int DEF_WIDTH_BITS        = 8;
   localparam int DEF_HEIGHT_BITS       = 8;
   localparam int DEF_FIFO_DEPTH_BITS   = 2;

   localparam logic [7:0] DROP_COUNT_MAX = 8'd255;

   typedef struct packed {
      logic [DEF_HEIGHT_BITS-1:0] row;
      logic [DEF_WIDTH_BITS-1:0]  col;
      logic                       data;
   } pixel_entry_t;

   function automatic int num_parallel(input int bits);
      return 1 << bits;
   endfunction

endpackage

// File: rtl/result_write_arbiter_lane_fifo.sv
// Per-lane synchronous FIFO; storage is not reset, only pointers and count.
module lane_fifo #(
   parameter int WIDTH      = 17,
   parameter int DEPTH_BITS = 2
) (
   input  logic                  clock,
   input  logic                  not_reset,
   input  logic                  push,
   input  logic                  pop,
   input  logic [WIDTH-1:0]      wdata,
   output logic [WIDTH-1:0]      rdata,
   output logic                  full,
   output logic                  empty,
   output logic [DEPTH_BITS:0]   count
);

   localparam int DEPTH = 2**DEPTH_BITS;

   logic [WIDTH-1:0]      mem [DEPTH];
   logic [DEPTH_BITS-1:0] wr_ptr;
   logic [DEPTH_BITS-1:0] rd_ptr;
   logic                  push_ok;
   logic                  pop_ok;

   // full is judged on the pre-edge count, so a same-cycle pop never frees room
   assign full    = (count == (DEPTH_BITS+1)'(DEPTH));
   assign empty   = (count == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clock or negedge not_reset) begin
      if (!not_reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + DEPTH_BITS'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + DEPTH_BITS'(1);
         case ({push_ok, pop_ok})
            2'b10:   count <= count + (DEPTH_BITS+1)'(1);
            2'b01:   count <= count - (DEPTH_BITS+1)'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (push_ok) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/result_write_arbiter.sv
// Merges box_filter lane results into one display write port via per-lane FIFOs
// and a round-robin drain, reporting overflow, drop count and frame completion.
module result_write_arbiter
   import result_write_arbiter_pkg::*;
#(
   parameter int NUM_PARALLEL_BITS = DEF_NUM_PARALLEL_BITS,
   parameter int WIDTH_BITS        = DEF_WIDTH_BITS,
   parameter int HEIGHT_BITS       = DEF_HEIGHT_BITS,
   parameter int FIFO_DEPTH_BITS   = DEF_FIFO_DEPTH_BITS
) (
   input  logic                                      clock,
   input  logic                                      not_reset,
   input  logic [num_parallel(NUM_PARALLEL_BITS)*WIDTH_BITS-1:0]  iResultCol,
   input  logic [num_parallel(NUM_PARALLEL_BITS)*HEIGHT_BITS-1:0] iResultRow,
   input  logic [num_parallel(NUM_PARALLEL_BITS)-1:0] iResultData,
   input  logic [num_parallel(NUM_PARALLEL_BITS)-1:0] iResultWren,
   input  logic                                      iAllFinished,
   output logic [num_parallel(NUM_PARALLEL_BITS)-1:0] oStall,
   output logic [HEIGHT_BITS-1:0]                    oX,
   output logic [WIDTH_BITS-1:0]                     oY,
   output logic [2:0]                                oR,
   output logic [2:0]                                oG,
   output logic [2:0]                                oB,
   output logic                                      oWren,
   output logic                                      oOverflow,
   output logic [7:0]                                oDropCount,
   output logic                                      oDone
);

   localparam int NUM_PARALLEL = num_parallel(NUM_PARALLEL_BITS);
   localparam int ENTRY_W      = HEIGHT_BITS + WIDTH_BITS + 1;
   localparam logic [FIFO_DEPTH_BITS:0] DEPTH_CNT = (FIFO_DEPTH_BITS+1)'(2**FIFO_DEPTH_BITS);

   typedef struct packed {
      logic [HEIGHT_BITS-1:0] row;
      logic [WIDTH_BITS-1:0]  col;
      logic                   data;
   } entry_t;

   entry_t                       push_entry [NUM_PARALLEL];
   entry_t                       pop_entry  [NUM_PARALLEL];
   logic [FIFO_DEPTH_BITS:0]     lane_count [NUM_PARALLEL];
   logic [NUM_PARALLEL-1:0]      full;
   logic [NUM_PARALLEL-1:0]      empty;
   logic [NUM_PARALLEL-1:0]      push;
   logic [NUM_PARALLEL-1:0]      pop;
   logic [NUM_PARALLEL-1:0]      drop;
   logic [NUM_PARALLEL_BITS-1:0] rr_ptr;
   logic [NUM_PARALLEL_BITS-1:0] cand;
   logic [NUM_PARALLEL_BITS-1:0] grant_idx;
   logic                         grant_valid;

   function automatic logic [7:0] sat_add_drops(input logic [7:0] cnt,
                                                input logic [NUM_PARALLEL-1:0] d);
      int sum;
      sum = int'(cnt);
      for (int i = 0; i < NUM_PARALLEL; i++) sum += int'(d[i]);
      if (sum > int'(DROP_COUNT_MAX)) return DROP_COUNT_MAX;
      return 8'(sum);
   endfunction

   for (genvar i = 0; i < NUM_PARALLEL; i++) begin : g_lane
      assign push_entry[i] = '{row:  iResultRow[i*HEIGHT_BITS +: HEIGHT_BITS],
                               col:  iResultCol[i*WIDTH_BITS +: WIDTH_BITS],
                               data: iResultData[i]};
      assign push[i]   = iResultWren[i] & ~full[i];
      assign drop[i]   = iResultWren[i] &  full[i];
      assign oStall[i] = (lane_count[i] == DEPTH_CNT);

      lane_fifo #(
         .WIDTH      (ENTRY_W),
         .DEPTH_BITS (FIFO_DEPTH_BITS)
      ) u_fifo (
         .clock     (clock),
         .not_reset (not_reset),
         .push      (push[i]),
         .pop       (pop[i]),
         .wdata     (push_entry[i]),
         .rdata     (pop_entry[i]),
         .full      (full[i]),
         .empty     (empty[i]),
         .count     (lane_count[i])
      );
   end

   // Round-robin search: first non-empty lane at or after the pointer, wrapping
   always_comb begin
      grant_valid = 1'b0;
      grant_idx   = rr_ptr;
      cand        = rr_ptr;
      for (int k = 0; k < NUM_PARALLEL; k++) begin
         cand = rr_ptr + k[NUM_PARALLEL_BITS-1:0];
         if (!grant_valid && !empty[cand]) begin
            grant_valid = 1'b1;
            grant_idx   = cand;
         end
      end
   end

   always_comb begin
      pop = '0;
      if (grant_valid) pop[grant_idx] = 1'b1;
   end

   always_ff @(posedge clock or negedge not_reset) begin
      if (!not_reset) begin
         rr_ptr     <= '0;
         oX         <= '0;
         oY         <= '0;
         oR         <= '0;
         oG         <= '0;
         oB         <= '0;
         oWren      <= 1'b0;
         oOverflow  <= 1'b0;
         oDropCount <= '0;
         oDone      <= 1'b0;
      end else begin
         oWren <= grant_valid;
         if (grant_valid) begin
            oX     <= pop_entry[grant_idx].row;
            oY     <= pop_entry[grant_idx].col;
            oR     <= {3{pop_entry[grant_idx].data}};
            oG     <= {3{pop_entry[grant_idx].data}};
            oB     <= {3{pop_entry[grant_idx].data}};
            rr_ptr <= grant_idx + NUM_PARALLEL_BITS'(1);
         end
         if (|drop) begin
            oOverflow  <= 1'b1;
            oDropCount <= sat_add_drops(oDropCount, drop);
         end
         oDone <= iAllFinished && (&empty) && !grant_valid;
      end
   end

endmodule
